// File: rtl/data_sram_like_slave_pkg.sv
// Shared types for the SRAM-like data slave: size encodings, packed request record,
// head FSM states and the byte-merge helper used on writes.
package data_sram_like_slave_pkg;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  // Width of one queued request: wr + size + addr + wstrb + wdata.
  localparam int SLV_REQ_WD = 1 + 2 + 32 + 4 + 32;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } slv_req_t;

  typedef enum logic [1:0] {
    HEAD_IDLE,
    HEAD_WAIT,
    HEAD_RESP
  } head_state_e;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order request queue for the SRAM-like slave; DEPTH entries, pointers wrap
// modulo DEPTH so non-power-of-two depths work.
module sram_like_req_fifo
  import data_sram_like_slave_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  slv_req_t      push_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output slv_req_t      head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SLV_REQ_WD-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = slv_req_t'(mem[rd_ptr]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; only pointers/count decide validity, and
  // leaving it out of reset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_sram_like_slave.sv
// SRAM-like data-bus responder: queues req/addr handshakes and answers each with one
// in-order data_ok after RESP_LAT wait cycles. Optional jitter via `define RAND_DELAY_EN.
module data_sram_like_slave
  import data_sram_like_slave_pkg::*;
#(
  parameter int MEM_AW   = 12,
  parameter int OUTST    = 2,
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CW = $clog2(OUTST + 1);
  localparam int LW = $clog2(RESP_LAT + 4) + 1;

  slv_req_t    req_in;
  slv_req_t    head;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [CW-1:0] count;

  head_state_e state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] lat_target;
  logic        open_q;
  logic        gate_ok;
  logic        head_start;
  logic        resp_fire;
  logic [MEM_AW-1:0] head_idx;
  logic [31:0] ram [2**MEM_AW];
  logic        unused_head;

  assign req_in = '{wr:    data_sram_wr,
                    size:  data_sram_size,
                    addr:  data_sram_addr,
                    wstrb: data_sram_wstrb,
                    wdata: data_sram_wdata};

  assign push = data_sram_req & data_sram_addr_ok;
  assign pop  = (state == HEAD_RESP);

  sram_like_req_fifo #(
    .DEPTH(OUTST),
    .CW   (CW)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .pop      (pop),
    .push_data(req_in),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  // Only entries already queued before RESP count as "another entry"; a push during
  // RESP goes through IDLE so it still sees the full RESP_LAT+1 latency.
  assign head_start = ((state == HEAD_IDLE) && !empty) ||
                      ((state == HEAD_RESP) && (count > CW'(1)));
  assign resp_fire  = (state == HEAD_WAIT) && (cnt >= lat_target);
  assign head_idx   = head.addr[MEM_AW+1:2];

`ifdef RAND_DELAY_EN
  logic [15:0] lfsr;
  logic [1:0]  extra;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr  <= 16'hACE1;
      extra <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (head_start) extra <= lfsr[2:1];
    end
  end

  assign gate_ok    = ~(lfsr[0] & lfsr[3]);
  assign lat_target = LW'(RESP_LAT) + LW'(extra);
`else
  assign gate_ok    = 1'b1;
  assign lat_target = LW'(RESP_LAT);
`endif

  // addr_ok depends only on registered state, never on req, so it cannot form a
  // combinational loop with a master that waits for addr_ok before raising req.
  assign data_sram_addr_ok = open_q & ~full & gate_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= HEAD_IDLE;
      cnt               <= '0;
      open_q            <= 1'b0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
    end else begin
      open_q            <= 1'b1;
      data_sram_data_ok <= 1'b0;
      case (state)
        HEAD_IDLE: begin
          if (head_start) begin
            state <= HEAD_WAIT;
            cnt   <= LW'(1);
          end
        end
        HEAD_WAIT: begin
          if (resp_fire) begin
            state             <= HEAD_RESP;
            data_sram_data_ok <= 1'b1;
            if (!head.wr) data_sram_rdata <= ram[head_idx];
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        HEAD_RESP: begin
          if (head_start) begin
            state <= HEAD_WAIT;
            cnt   <= LW'(1);
          end else begin
            state <= HEAD_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= HEAD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resp_fire && head.wr) begin
      ram[head_idx] <= merge_wstrb(ram[head_idx], head.wdata, head.wstrb);
    end
  end

  // size is informational and the byte lane / aliased address bits are ignored.
  assign unused_head = ^{head.size, head.addr[31:MEM_AW+2], head.addr[1:0]};

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Scoreboard bench for data_sram_like_slave: stimulus queues expected responses,
// a negedge monitor checks each data_ok (order, cycle, rdata) and addr_ok.
module tb_data_sram_like_slave;
  import data_sram_like_slave_pkg::*;

  localparam int MEM_AW   = 12;
  localparam int OUTST    = 2;
  localparam int RESP_LAT = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          acc_cyc;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   last_exp = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  data_sram_like_slave #(
    .MEM_AW  (MEM_AW),
    .OUTST   (OUTST),
    .RESP_LAT(RESP_LAT)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_addr   (addr),
    .data_sram_wstrb  (wstrb),
    .data_sram_wdata  (wdata),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: at each negedge, compare addr_ok with the bench's in-flight count and
  // retire one scoreboard entry per data_ok.
  always @(negedge clk) begin
    int   inflight;
    exp_t e;
    if (resetn && mon_en) begin
      inflight = 0;
      foreach (sb[i]) if (sb[i].acc_cyc <= cyc) inflight++;
`ifndef RAND_DELAY_EN
      check("addr_ok", {31'b0, addr_ok}, {31'b0, inflight < OUTST});
`endif
      if (data_ok) begin
        if (sb.size() == 0) begin
          check("unexpected_data_ok", {31'b0, data_ok}, 32'd0);
        end else begin
          e = sb.pop_front();
`ifndef RAND_DELAY_EN
          check("resp_cycle", cyc, e.exp_cyc);
`endif
          if (e.is_rd) check("rdata", rdata, e.data);
        end
      end
    end
  end

  // Called at a negedge; returns one negedge after the request is accepted, req still high.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] exp_rd);
    int   waited;
    exp_t e;
    waited = 0;
    req   = 1'b1;
    wr    = w;
    size  = sz;
    addr  = a;
    wstrb = strb;
    wdata = wd;
    while (!addr_ok && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!addr_ok) begin
      check("accept_timeout", {31'b0, addr_ok}, 32'd1);
    end else begin
      e.is_rd   = ~w;
      e.data    = exp_rd;
      e.acc_cyc = cyc + 1;
      e.exp_cyc = e.acc_cyc + RESP_LAT + 1;
      if (last_exp + RESP_LAT + 1 > e.exp_cyc) e.exp_cyc = last_exp + RESP_LAT + 1;
      last_exp = e.exp_cyc;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, SRAM_SIZE_WORD, a, 4'hF, d, 32'h0);
  endtask

  task automatic rd_word(input logic [31:0] a, input logic [31:0] exp_rd);
    issue(1'b0, SRAM_SIZE_WORD, a, 4'h0, 32'h0, exp_rd);
  endtask

  task automatic drain();
    int waited;
    req    = 1'b0;
    waited = 0;
    while (sb.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    req    = 1'b1;
    wr     = 1'b0;
    size   = SRAM_SIZE_WORD;
    addr   = 32'h100;
    wstrb  = 4'h0;
    wdata  = 32'h0;

    // Reset held with req high: nothing accepted, nothing answered.
    repeat (3) @(negedge clk);
    check("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
    check("rst_data_ok", {31'b0, data_ok}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    #1 check("release_addr_ok_low", {31'b0, addr_ok}, 32'd0);
    @(negedge clk);
    check("post_release_addr_ok", {31'b0, addr_ok}, 32'd1);
    req    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Word write then read.
    wr_word(32'h100, 32'hDEADBEEF);
    req = 1'b0;
    repeat (4) @(negedge clk);
    rd_word(32'h100, 32'hDEADBEEF);
    drain();

    // Byte merge into the top lane, queued back to back.
    wr_word(32'h200, 32'h11223344);
    issue(1'b1, SRAM_SIZE_BYTE, 32'h203, 4'b1000, 32'hAA000000, 32'h0);
    rd_word(32'h200, 32'hAA223344);
    drain();

    // Read accepted before the preceding write is answered sees the new data.
    wr_word(32'h300, 32'h00000005);
    rd_word(32'h300, 32'h00000005);
    drain();

    // wstrb=0 write leaves the word alone but still answers.
    issue(1'b1, SRAM_SIZE_WORD, 32'h300, 4'b0000, 32'hFFFFFFFF, 32'h0);
    rd_word(32'h300, 32'h00000005);
    drain();

    // Half-word write to the upper lanes.
    issue(1'b1, SRAM_SIZE_HALF, 32'h202, 4'b1100, 32'hBBBB0000, 32'h0);
    rd_word(32'h200, 32'hBBBB3344);
    drain();

    // addr[1:0] ignored and bits above MEM_AW+1 alias.
    rd_word(32'h00004101, 32'hDEADBEEF);
    drain();

    // Backpressure: four reads with req held high against a two-deep queue.
    rd_word(32'h100, 32'hDEADBEEF);
    rd_word(32'h200, 32'hBBBB3344);
    rd_word(32'h300, 32'h00000005);
    rd_word(32'h4100, 32'hDEADBEEF);
    drain();

    // Reset with two requests in flight: they must never be answered.
    rd_word(32'h100, 32'hDEADBEEF);
    rd_word(32'h200, 32'hBBBB3344);
    resetn = 1'b0;
    req    = 1'b0;
    mon_en = 1'b0;
    sb.delete();
    last_exp = 0;
    #1 check("midrst_data_ok", {31'b0, data_ok}, 32'd0);
    check("midrst_addr_ok", {31'b0, addr_ok}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Queue empty after reset (two immediate accepts); RAM contents survive reset.
    rd_word(32'h100, 32'hDEADBEEF);
    rd_word(32'h300, 32'h00000005);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
